// File: rtl/npu_pkg.sv
// Shared types and defaults for the NPU instruction path.
package npu_pkg;

    localparam int unsigned          NPU_W_IN      = 8;
    localparam logic [NPU_W_IN-1:0]  NPU_NOP_INSTR = 8'h00;

    typedef enum logic {
        IDLE,
        ISSUE
    } issue_state_e;

endpackage

// File: rtl/npu_instr_fifo.sv
// Synchronous FIFO with flush; head word is presented combinationally on rdata.
module npu_instr_fifo #(
    parameter int unsigned W     = 12,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          do_push, do_pop;

    assign full  = (fill_q == FW'(DEPTH));
    assign empty = (fill_q == '0);
    assign fill  = fill_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push coinciding with flush is dropped.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   fill_d = fill_q + FW'(1);
                2'b01:   fill_d = fill_q - FW'(1);
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/npu_instr_issuer.sv
// Buffers host instruction words and issues them to the scheduler, holding
// each word for host_rep+1 cycles and driving NOP when idle.
module npu_instr_issuer
    import npu_pkg::*;
#(
    parameter int unsigned      W_IN      = NPU_W_IN,
    parameter int unsigned      DEPTH     = 16,
    parameter int unsigned      REP_W     = 4,
    parameter logic [W_IN-1:0]  NOP_INSTR = W_IN'(NPU_NOP_INSTR)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        host_valid,
    output logic                        host_ready,
    input  logic [W_IN-1:0]             host_instr,
    input  logic [REP_W-1:0]            host_rep,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        flush,
    output logic [W_IN-1:0]             instr_out,
    output logic                        instr_valid,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(DEPTH+1)-1:0]  fill
);

    localparam int unsigned EW = REP_W + W_IN;

    issue_state_e     state_q, state_d;
    logic [W_IN-1:0]  cur_instr_q, cur_instr_d;
    logic [REP_W-1:0] cur_rep_q, cur_rep_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [W_IN-1:0]  instr_out_q, instr_out_d;
    logic             instr_valid_q, instr_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [EW-1:0]    fifo_rdata;
    logic [W_IN-1:0]  head_instr;
    logic [REP_W-1:0] head_rep;

    assign host_ready = !fifo_full && !rst_n;
    assign head_instr = fifo_rdata[W_IN-1:0];
    assign head_rep   = fifo_rdata[W_IN +: REP_W];

    npu_instr_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .push  (host_valid && host_ready),
        .pop   (fifo_pop),
        .flush (flush),
        .wdata ({host_rep, host_instr}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .fill  (fill)
    );

    always_comb begin
        state_d     = state_q;
        cur_instr_d = cur_instr_q;
        cur_rep_d   = cur_rep_q;
        rep_cnt_d   = rep_cnt_q;
        fifo_pop    = 1'b0;
        done_d      = 1'b0;

        if (flush) begin
            state_d = IDLE;
        end else if (state_q == ISSUE) begin
            if (stop) begin
                state_d = IDLE;
            end else if (rep_cnt_q != cur_rep_q) begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end else if (!fifo_empty) begin
                // Back-to-back pop keeps the issue stream bubble-free.
                fifo_pop    = 1'b1;
                cur_instr_d = head_instr;
                cur_rep_d   = head_rep;
                rep_cnt_d   = '0;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (start && !stop && !fifo_empty) begin
            fifo_pop    = 1'b1;
            cur_instr_d = head_instr;
            cur_rep_d   = head_rep;
            rep_cnt_d   = '0;
            state_d     = ISSUE;
        end

        // Outputs are registered, so they are derived from the next state.
        instr_valid_d = (state_d == ISSUE);
        busy_d        = (state_d == ISSUE);
        instr_out_d   = (state_d == ISSUE) ? cur_instr_d : NOP_INSTR;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= IDLE;
            cur_instr_q   <= NOP_INSTR;
            cur_rep_q     <= '0;
            rep_cnt_q     <= '0;
            instr_out_q   <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_instr_q   <= cur_instr_d;
            cur_rep_q     <= cur_rep_d;
            rep_cnt_q     <= rep_cnt_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign instr_out   = instr_out_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_npu_instr_issuer.sv
// Self-checking bench for npu_instr_issuer: table vectors, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_npu_instr_issuer;

    localparam int unsigned DEPTH = 16;
    localparam logic [7:0]  NOP   = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] host_instr;
    logic [3:0] host_rep;
    logic       start;
    logic       stop;
    logic       flush;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       busy;
    logic       done;
    logic [4:0] fill;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    npu_instr_issuer #(
        .W_IN      (8),
        .DEPTH     (DEPTH),
        .REP_W     (4),
        .NOP_INSTR (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_instr  (host_instr),
        .host_rep    (host_rep),
        .start       (start),
        .stop        (stop),
        .flush       (flush),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .fill        (fill)
    );

    // Reference model: a queue of pending words plus the word being held
    // and how many more cycles it stays on the output.
    typedef logic [11:0] ent_t;
    ent_t       q[$];
    bit         m_issuing = 0;
    logic [7:0] m_instr   = NOP;
    int         m_left    = 0;
    bit         m_done    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit   acc;
        ent_t e;
        acc    = host_valid && (q.size() != DEPTH) && !rst_n;
        m_done = 0;
        if (rst_n || flush) begin
            q.delete();
            m_issuing = 0;
        end else begin
            if (m_issuing) begin
                if (stop) begin
                    m_issuing = 0;
                end else if (m_left > 0) begin
                    m_left--;
                end else if (q.size() > 0) begin
                    e       = q.pop_front();
                    m_instr = e[7:0];
                    m_left  = int'(e[11:8]);
                end else begin
                    m_issuing = 0;
                    m_done    = 1;
                end
            end else if (start && !stop && q.size() > 0) begin
                e         = q.pop_front();
                m_instr   = e[7:0];
                m_left    = int'(e[11:8]);
                m_issuing = 1;
            end
            if (acc) q.push_back({host_rep, host_instr});
        end
    endtask

    task automatic check_model();
        chk("instr_out",   32'(instr_out),   32'(m_issuing ? m_instr : NOP));
        chk("instr_valid", 32'(instr_valid), 32'(m_issuing));
        chk("busy",        32'(busy),        32'(m_issuing));
        chk("done",        32'(done),        32'(m_done));
        chk("fill",        32'(fill),        32'(q.size()));
        chk("host_ready",  32'(host_ready),  32'((q.size() != DEPTH) && !rst_n));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        host_valid = 1'b0;
        host_instr = 8'h00;
        host_rep   = 4'd0;
        start      = 1'b0;
        stop       = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] w, input logic [3:0] r);
        idle_inputs();
        host_valid = 1'b1;
        host_instr = w;
        host_rep   = r;
        cycle();
        idle_inputs();
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1'b1;
        cycle();
        idle_inputs();
    endtask

    typedef struct {
        logic       hv;
        logic [7:0] instr;
        logic [3:0] rep;
        logic       start;
        logic [7:0] e_instr;
        logic       e_valid;
        logic       e_done;
        logic [4:0] e_fill;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 8'h11, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1};
        vecs[1] = '{1'b1, 8'h22, 4'd2, 1'b0, 8'h00, 1'b0, 1'b0, 5'd2};
        vecs[2] = '{1'b1, 8'h33, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd3};
        vecs[3] = '{1'b0, 8'h00, 4'd0, 1'b1, 8'h11, 1'b1, 1'b0, 5'd2};
        vecs[4] = '{1'b0, 8'h00, 4'd0, 1'b0, 8'h22, 1'b1, 1'b0, 5'd1};
        vecs[5] = '{1'b0, 8'h00, 4'd0, 1'b0, 8'h22, 1'b1, 1'b0, 5'd1};
        vecs[6] = '{1'b0, 8'h00, 4'd0, 1'b0, 8'h22, 1'b1, 1'b0, 5'd1};
        vecs[7] = '{1'b0, 8'h00, 4'd0, 1'b0, 8'h33, 1'b1, 1'b0, 5'd0};
        vecs[8] = '{1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0};
        vecs[9] = '{1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};

        idle_inputs();
        rst_n = 1'b1;
        cycle();
        cycle();
        chk("reset_host_ready", 32'(host_ready), 32'd0);
        rst_n = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("idle_instr", 32'(instr_out), 32'h00);
            chk("idle_ready", 32'(host_ready), 32'd1);
        end

        // Table-driven basic program with repeats.
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            host_valid = vecs[i].hv;
            host_instr = vecs[i].instr;
            host_rep   = vecs[i].rep;
            start      = vecs[i].start;
            cycle();
            chk($sformatf("vec%0d_instr", i), 32'(instr_out),   32'(vecs[i].e_instr));
            chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_done", i),  32'(done),        32'(vecs[i].e_done));
            chk($sformatf("vec%0d_fill", i),  32'(fill),        32'(vecs[i].e_fill));
        end
        idle_inputs();

        // Fill to capacity; the 17th push is refused.
        for (int i = 0; i < 17; i++) begin
            idle_inputs();
            host_valid = 1'b1;
            host_instr = 8'(8'h40 + i);
            host_rep   = 4'(i % 3);
            cycle();
        end
        chk("full_fill",  32'(fill),       32'd16);
        chk("full_ready", 32'(host_ready), 32'd0);
        // Start with a push on the same edge (refused: full), then keep pushing.
        host_instr = 8'hEE;
        start      = 1'b1;
        cycle();
        start = 1'b0;
        chk("full_first_issue", 32'(instr_out), 32'h40);
        for (int i = 0; i < 30; i++) begin
            host_valid = 1'(i % 2);
            host_instr = 8'(8'hA0 + i);
            host_rep   = 4'(i % 2);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 80; i++) cycle();
        do_flush();

        // Stop mid-issue: current word discarded, remaining words retained.
        push_word(8'h51, 4'd3);
        push_word(8'h52, 4'd3);
        push_word(8'h53, 4'd3);
        push_word(8'h54, 4'd3);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("stop_instr", 32'(instr_out),   32'h00);
        chk("stop_valid", 32'(instr_valid), 32'd0);
        chk("stop_done",  32'(done),        32'd0);
        chk("stop_fill",  32'(fill),        32'd2);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("restart_instr", 32'(instr_out), 32'h53);
        for (int i = 0; i < 10; i++) cycle();
        chk("restart_drained", 32'(fill), 32'd0);

        // Flush mid-issue with a simultaneous push.
        push_word(8'h61, 4'd2);
        push_word(8'h62, 4'd2);
        push_word(8'h63, 4'd2);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        host_valid = 1'b1;
        host_instr = 8'h6F;
        flush      = 1'b1;
        cycle();
        idle_inputs();
        chk("flush_fill",  32'(fill),      32'd0);
        chk("flush_instr", 32'(instr_out), 32'h00);
        chk("flush_done",  32'(done),      32'd0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("flush_start_ignored", 32'(instr_valid), 32'd0);
        cycle();

        // Reset asserted for one cycle mid-issue.
        push_word(8'h71, 4'd2);
        push_word(8'h72, 4'd2);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("rst_instr", 32'(instr_out),   32'h00);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_fill",  32'(fill),        32'd0);
        chk("rst_ready", 32'(host_ready),  32'd0);
        rst_n = 1'b0;
        cycle();
        chk("post_rst_ready", 32'(host_ready), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 299) == 0);
            flush      = ($urandom_range(0, 59) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            start      = ($urandom_range(0, 7) == 0);
            host_valid = ($urandom_range(0, 1) == 0);
            host_instr = 8'($urandom);
            host_rep   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            cycle();
        end
        idle_inputs();
        rst_n = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/npu_instr_issuer.md
Name: npu_instr_issuer

Overview:
Upstream feeder for npu_scheduler. It buffers instruction words from the host/controller through a valid/ready interface. On command, it issues the buffered words onto the scheduler's `instr` input, holding each word for a programmable number of cycles. When no instruction is issued it drives a NOP word, so the PE array sees idle.

Parameters:
W_IN, 8, instruction width; must match npu_scheduler W_IN
DEPTH, 16, instruction buffer entries; power of 2, ≥2
REP_W, 4, width of per-instruction repeat field
NOP_INSTR, 8'h00, word driven on instr_out when not issuing

Ports:
clk  in  1  work clock
rst_n  in  1  reset; synchronous, active-high (asserted = 1)
host_valid  in  1  host word available
host_ready  out  1  buffer can accept a word
host_instr  in  W_IN  instruction word
host_rep  in  REP_W  extra hold cycles; word is issued host_rep+1 cycles
start  in  1  begin issuing buffered program
stop  in  1  abort issue; buffer contents retained
flush  in  1  discard buffer and abort
instr_out  out  W_IN  to npu_scheduler.instr
instr_valid  out  1  instr_out carries a real instruction
busy  out  1  state == ISSUE
done  out  1  one-cycle pulse: buffer drained normally
fill  out  $clog2(DEPTH+1)  current buffer occupancy

Behaviour:
- Reset (rst_n=1 at a clk edge): FIFO empty, fill=0, state=IDLE, instr_out=NOP_INSTR, instr_valid=0, busy=0, done=0. host_ready=0 while rst_n=1.
- Push: host_ready = (fill != DEPTH) && !rst_n. A word is written at an edge where host_valid && host_ready. Pushes are legal in any state.
- FSM states: IDLE, ISSUE.
- IDLE:
  - instr_out=NOP_INSTR, instr_valid=0.
  - start && fill!=0: pop the head into cur_instr/cur_rep, clear rep_cnt, go to ISSUE. The first word appears on instr_out the cycle after start is sampled (latency 1).
  - start with fill==0: ignored; no done pulse.
- ISSUE:
  - instr_out=cur_instr, instr_valid=1, busy=1.
  - Each cycle: if rep_cnt != cur_rep, rep_cnt++.
  - When rep_cnt == cur_rep and fill!=0: pop the next word in the same edge, with no bubble between instructions.
  - When rep_cnt == cur_rep and fill==0: go to IDLE and pulse done for 1 cycle, coincident with the first NOP cycle.
  - A push into an empty FIFO in the final hold cycle is not visible for the pop; the block ends with done.
- stop in ISSUE: go to IDLE next edge; the current instruction is discarded; FIFO is kept; no done. stop in IDLE: no effect.
- flush (any state): FIFO cleared (fill=0), state=IDLE, no done. A push in the same cycle as flush is dropped.
- Priority: rst_n > flush > stop > start > normal progression.
- Simultaneous push and pop: fill unchanged. Full FIFO with a pop the same cycle: the push is still refused (host_ready is based on registered fill).
- Pointers: log2(DEPTH) bits, wrap naturally. fill is a separate counter, saturating at 0..DEPTH by construction.
- All outputs are registered except host_ready (combinational from fill and rst_n).

Decomposition:
- Package npu_pkg:
  - state typedef enum {IDLE, ISSUE}
  - NOP_INSTR default constant
  - W_IN default shared with npu_scheduler
- Sub-module npu_instr_fifo: synchronous FIFO of {rep, instr}, DEPTH entries, with push/pop/flush and full/empty/fill outputs. The FSM and hold counter live in npu_instr_issuer.

Test Plan:
- Reset then idle → instr_out=8'h00, instr_valid=0, host_ready=1, fill=0 for 5 cycles.
- Push 8'h11/rep0, 8'h22/rep2, 8'h33/rep0; pulse start → from the next cycle instr_out = 11, 22, 22, 22, 33, then 00. done is high exactly on the first 00 cycle. busy is high for 5 cycles.
- Push 16 words while idle → host_ready=0 at fill=16, and a 17th push is refused. Start, then push during issue → refused word never appears; accepted words issue in FIFO order.
- Start issue of 4 words with rep3, assert stop on cycle 6 → IDLE next cycle, instr_out=00, fill=2, no done. Restart → remaining 2 words issue.
- Assert flush mid-issue with a simultaneous push → fill=0, instr_out=00 next cycle, no done. Start afterwards is ignored.
- Assert rst_n for 1 cycle mid-issue → all outputs at reset values next cycle, FIFO empty.
